// File: rtl/fir_ctrl_pkg.sv
// Shared sizes, state encoding and helpers for the DA FIR LUT loader.
package fir_ctrl_pkg;

  localparam int NUM_TAPS   = 64;
  localparam int GROUP_SIZE = 8;
  localparam int NUM_GROUPS = 8;
  localparam int LUT_DEPTH  = 2048;
  localparam int COEF_W     = 16;
  localparam int CIN_W      = 19;
  localparam int CADDR_W    = 11;
  localparam int CNT_W      = 7;

  localparam logic [CADDR_W-1:0] LAST_ADDR = 11'd2047;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  function automatic logic [31:0] sext_entry(input logic signed [CIN_W-1:0] v);
    return {{(32-CIN_W){v[CIN_W-1]}}, v};
  endfunction

endpackage

// File: rtl/fir_da_subset_sum.sv
// Combinational masked sum of one 8-coefficient group: one DA LUT entry.
module fir_da_subset_sum
  import fir_ctrl_pkg::*;
(
  input  logic signed [COEF_W-1:0] coef [GROUP_SIZE],
  input  logic        [GROUP_SIZE-1:0] mask,
  output logic signed [CIN_W-1:0]  sum
);

  logic signed [CIN_W-1:0] term_s [GROUP_SIZE];
  logic signed [CIN_W-1:0] lvl1_s [4];
  logic signed [CIN_W-1:0] lvl2_s [2];

  // Sign-extend selected coefficients; unselected ones contribute zero.
  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (mask[i]) begin
        term_s[i] = {{(CIN_W-COEF_W){coef[i][COEF_W-1]}}, coef[i]};
      end else begin
        term_s[i] = {CIN_W{1'b0}};
      end
    end
  end

  // First adder-tree level.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1_s[i] = term_s[2*i] + term_s[2*i+1];
    end
  end

  // Second adder-tree level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl2_s[i] = lvl1_s[2*i] + lvl1_s[2*i+1];
    end
  end

  assign sum = lvl2_s[0] + lvl2_s[1];

endmodule

// File: rtl/fir_da_lut_loader.sv
// Collects 64 coefficients, then streams all 2048 DA LUT entries to fir_filter.
// Optional running checksum of written entries: define FIR_LUT_CHECKSUM_EN.
module fir_da_lut_loader
  import fir_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 192
) (
  input  logic                     clk_fast,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic signed [CIN_W-1:0]  CIN,
  output logic [CADDR_W-1:0]       CADDR,
  output logic                     CLOAD,
  output logic                     filter_en,
  output logic [31:0]              lut_checksum
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ld_state_e                state_r;
  logic [CNT_W-1:0]         coef_cnt_r;
  logic [HOLD_W-1:0]        hold_cnt_r;
  logic signed [COEF_W-1:0] coef_mem_r [NUM_TAPS];

  logic                     go_s;
  logic                     wr_s;
  logic                     hold_end_s;
  logic [CADDR_W-1:0]       load_addr_s;
  logic signed [COEF_W-1:0] grp_s [GROUP_SIZE];
  logic signed [CIN_W-1:0]  entry_s;

  // Handshake/start qualification and the address whose entry loads next.
  always_comb begin
    go_s        = 1'b0;
    wr_s        = 1'b0;
    load_addr_s = {CADDR_W{1'b0}};
    if (state_r == IDLE) begin
      go_s = start && (coef_cnt_r == 7'(NUM_TAPS));
      wr_s = coef_valid && coef_ready && !go_s;
    end else begin
      go_s = 1'b0;
      wr_s = 1'b0;
    end
    if (state_r == GEN) begin
      load_addr_s = CADDR + 11'd1;
    end else begin
      load_addr_s = {CADDR_W{1'b0}};
    end
    hold_end_s = (state_r == GEN) && (hold_cnt_r == HOLD_LAST);
  end

  // Route the coefficient group selected by the upper address bits.
  always_comb begin
    for (int b = 0; b < GROUP_SIZE; b++) begin
      grp_s[b] = coef_mem_r[{load_addr_s[CADDR_W-1:8], 3'(b)}];
    end
  end

  fir_da_subset_sum u_subset_sum (
    .coef (grp_s),
    .mask (load_addr_s[7:0]),
    .sum  (entry_s)
  );

  // Coefficient register file; deliberately not cleared by reset.
  always_ff @(posedge clk_fast) begin
    if (wr_s) begin
      coef_mem_r[coef_cnt_r[5:0]] <= coef_in;
    end
  end

  // Load sequencer with registered load-port and status outputs.
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      coef_cnt_r <= 7'd0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      coef_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      CIN        <= 19'sd0;
      CADDR      <= 11'd0;
      CLOAD      <= 1'b0;
      filter_en  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go_s) begin
            state_r    <= GEN;
            hold_cnt_r <= {HOLD_W{1'b0}};
            coef_ready <= 1'b0;
            busy       <= 1'b1;
            CLOAD      <= 1'b1;
            CADDR      <= 11'd0;
            CIN        <= entry_s;
          end else if (wr_s) begin
            coef_cnt_r <= coef_cnt_r + 7'd1;
            coef_ready <= (coef_cnt_r < 7'd63);
            filter_en  <= 1'b0;
          end else begin
            coef_ready <= (coef_cnt_r < 7'(NUM_TAPS));
          end
        end
        GEN: begin
          if (hold_end_s) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            if (CADDR == LAST_ADDR) begin
              // CIN/CADDR keep the final entry; a new load needs 64 fresh taps.
              state_r    <= DONE;
              CLOAD      <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              filter_en  <= 1'b1;
              coef_cnt_r <= 7'd0;
            end else begin
              CADDR <= load_addr_s;
              CIN   <= entry_s;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        DONE: begin
          state_r    <= IDLE;
          coef_ready <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          coef_ready <= 1'b0;
          busy       <= 1'b0;
          CLOAD      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIR_LUT_CHECKSUM_EN
  logic [31:0] csum_r;

  // Add each entry once, on the first cycle its address is presented.
  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      csum_r <= 32'd0;
    end else if (go_s) begin
      csum_r <= 32'd0;
    end else if ((state_r == GEN) && (hold_cnt_r == {HOLD_W{1'b0}})) begin
      csum_r <= csum_r + sext_entry(CIN);
    end else begin
      csum_r <= csum_r;
    end
  end

  assign lut_checksum = csum_r;
`else
  assign lut_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_fir_da_lut_loader.sv
// Randomized self-checking bench for fir_da_lut_loader against a cycle-level behavioural model.
module tb_fir_da_lut_loader;

  localparam int H = 4;
  localparam int GEN_CYC = 2048 * H;
`ifdef FIR_LUT_CHECKSUM_EN
  localparam logic [31:0] ONES_SUM = 32'd8192;
`else
  localparam logic [31:0] ONES_SUM = 32'd0;
`endif

  logic               clk_fast = 1'b0;
  logic               reset;
  logic signed [15:0] coef_in;
  logic               coef_valid;
  logic               coef_ready;
  logic               start;
  logic               busy;
  logic               done;
  logic signed [18:0] CIN;
  logic [10:0]        CADDR;
  logic               CLOAD;
  logic               filter_en;
  logic [31:0]        lut_checksum;

  fir_da_lut_loader #(.HOLD_CYCLES(H)) dut (
    .clk_fast     (clk_fast),
    .reset        (reset),
    .coef_in      (coef_in),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .CIN          (CIN),
    .CADDR        (CADDR),
    .CLOAD        (CLOAD),
    .filter_en    (filter_en),
    .lut_checksum (lut_checksum)
  );

  always #5 clk_fast = ~clk_fast;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic signed [15:0] m_coef [64];
  int                 m_phase = 0;   // 0 idle, 1 generating, 2 done cycle
  int                 m_cnt   = 0;
  int                 m_t     = 0;   // cycles elapsed in generation
  int                 m_caddr = 0;
  int                 m_cin   = 0;
  bit                 m_fen   = 1'b0;
  logic [31:0]        m_csum  = 32'd0;

  function automatic int entry_of(input int a);
    int s;
    int g;
    int m;
    s = 0;
    g = a / 256;
    m = a % 256;
    for (int b = 0; b < 8; b++) begin
      if (((m >> b) & 1) == 1) s += int'(m_coef[8*g+b]);
    end
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk_fast or posedge reset);
      if (reset) begin
        m_phase = 0; m_cnt = 0; m_t = 0; m_caddr = 0; m_cin = 0; m_fen = 1'b0; m_csum = 32'd0;
      end else begin
        case (m_phase)
          0: begin
            if (start && m_cnt == 64) begin
              m_phase = 1; m_t = 0; m_caddr = 0; m_cin = entry_of(0); m_csum = 32'd0;
            end else if (coef_valid && m_cnt < 64) begin
              m_coef[m_cnt] = coef_in; m_cnt++; m_fen = 1'b0;
            end
          end
          1: begin
            if (m_t % H == 0) m_csum = m_csum + 32'(m_cin);
            m_t++;
            if (m_t == GEN_CYC) begin
              m_phase = 2; m_fen = 1'b1; m_cnt = 0;
            end else begin
              m_caddr = m_t / H; m_cin = entry_of(m_caddr);
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [18:0] ecin;
    logic [31:0] ecsum;
    forever begin
      @(negedge clk_fast);
      ecin = m_cin[18:0];
`ifdef FIR_LUT_CHECKSUM_EN
      ecsum = m_csum;
`else
      ecsum = 32'd0;
`endif
      chk("cload", {31'd0, CLOAD}, {31'd0, m_phase == 1});
      chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
      chk("done", {31'd0, done}, {31'd0, m_phase == 2});
      chk("coef_ready", {31'd0, coef_ready}, {31'd0, (m_phase == 0) && (m_cnt < 64)});
      chk("filter_en", {31'd0, filter_en}, {31'd0, m_fen});
      chk("caddr", {21'd0, CADDR}, 32'(m_caddr));
      chk("cin", {13'd0, CIN}, {13'd0, ecin});
      chk("checksum", lut_checksum, ecsum);
    end
  end

  // ---------------- stimulus ----------------
  logic signed [15:0] src [64];
  logic [10:0]        ck_addr [4];
  logic [18:0]        ck_val  [4];

  task automatic load_range(input int lo, input int hi);
    int idx;
    int guard;
    bit acc;
    idx = lo;
    guard = 0;
    while (idx < hi && guard < 4000) begin
      if ($urandom_range(0, 3) == 0) begin
        coef_valid = 1'b0;
        coef_in = 16'($urandom);
        @(posedge clk_fast); #1;
      end else begin
        coef_valid = 1'b1;
        coef_in = src[idx];
        @(negedge clk_fast);
        acc = coef_ready;
        @(posedge clk_fast); #1;
        if (acc) idx++;
      end
      guard++;
    end
    coef_valid = 1'b0;
    chk("load_complete", 32'(idx), 32'(hi));
  endtask

  task automatic run_gen(input int nchk, input bit chk_sum, input logic [31:0] exp_sum);
    int  cl;
    int  cyc;
    bit  fin;
    bit  seen [4];
    cl = 0; cyc = 0; fin = 1'b0;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    start = 1'b1;
    @(posedge clk_fast); #1;
    start = 1'b0;
    while (!fin && cyc < GEN_CYC + 32) begin
      @(negedge clk_fast);
      cyc++;
      if (CLOAD) cl++;
      for (int k = 0; k < nchk; k++) begin
        if (CLOAD && CADDR == ck_addr[k] && !seen[k]) begin
          seen[k] = 1'b1;
          chk("lit_cin", {13'd0, CIN}, {13'd0, ck_val[k]});
        end
      end
      if (done) begin
        fin = 1'b1;
        coef_valid = 1'b0;
        if (chk_sum) chk("lit_checksum", lut_checksum, exp_sum);
      end
    end
    chk("gen_finished", {31'd0, fin}, 32'd1);
    chk("cload_cycles", 32'(cl), 32'(GEN_CYC));
    for (int k = 0; k < nchk; k++) chk("lit_addr_seen", {31'd0, seen[k]}, 32'd1);
    @(negedge clk_fast);
    chk("done_single", {31'd0, done}, 32'd0);
    chk("fen_after_done", {31'd0, filter_en}, 32'd1);
    @(posedge clk_fast); #1;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; coef_valid = 1'b0; coef_in = 16'sd0; start = 1'b0;
    repeat (3) @(posedge clk_fast);
    #1;
    chk("rst_ready", {31'd0, coef_ready}, 32'd1);
    chk("rst_cload", {31'd0, CLOAD}, 32'd0);
    chk("rst_fen", {31'd0, filter_en}, 32'd0);
    chk("rst_caddr", {21'd0, CADDR}, 32'd0);
    reset = 1'b0;
    @(posedge clk_fast); #1;

    // All-ones coefficients.
    for (int k = 0; k < 64; k++) src[k] = 16'sd1;
    load_range(0, 64);
    ck_addr[0] = 11'd0;   ck_val[0] = 19'd0;
    ck_addr[1] = 11'd255; ck_val[1] = 19'd8;
    ck_addr[2] = 11'd271; ck_val[2] = 19'd4;
    ck_addr[3] = 11'd2047; ck_val[3] = 19'd8;
    run_gen(4, 1'b1, ONES_SUM);

    // coef[k] = k-32, with an early start on 63 taps and a 65th offer.
    for (int k = 0; k < 64; k++) src[k] = 16'(k - 32);
    load_range(0, 63);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk_fast);
      chk("short_busy", {31'd0, busy}, 32'd0);
      chk("short_cload", {31'd0, CLOAD}, 32'd0);
    end
    @(posedge clk_fast); #1;
    start = 1'b0;
    load_range(63, 64);
    coef_valid = 1'b1;
    coef_in = 16'sh1234;
    repeat (3) begin
      @(negedge clk_fast);
      chk("full_ready_low", {31'd0, coef_ready}, 32'd0);
    end
    @(posedge clk_fast); #1;
    ck_addr[0] = 11'd3;     ck_val[0] = 19'h7FFC1;
    ck_addr[1] = 11'h700;   ck_val[1] = 19'd0;
    ck_addr[2] = 11'h780;   ck_val[2] = 19'd31;
    run_gen(3, 1'b0, 32'd0);

    // Most-negative coefficients.
    for (int k = 0; k < 64; k++) src[k] = 16'sh8000;
    load_range(0, 64);
    ck_addr[0] = 11'd255;  ck_val[0] = 19'h40000;
    ck_addr[1] = 11'd2047; ck_val[1] = 19'h40000;
    run_gen(2, 1'b0, 32'd0);

    // Random coefficients, reset in the middle of generation.
    for (int k = 0; k < 64; k++) src[k] = 16'($urandom);
    load_range(0, 64);
    start = 1'b1;
    @(posedge clk_fast); #1;
    start = 1'b0;
    cyc = 0;
    while (!(CLOAD && CADDR == 11'd1000) && cyc < GEN_CYC) begin
      @(negedge clk_fast);
      cyc++;
    end
    chk("reached_addr_1000", {21'd0, CADDR}, 32'd1000);
    @(posedge clk_fast); #1;
    reset = 1'b1;
    #1;
    chk("midrst_cload", {31'd0, CLOAD}, 32'd0);
    chk("midrst_fen", {31'd0, filter_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, coef_ready}, 32'd1);
    @(posedge clk_fast); #1;
    reset = 1'b0;
    for (int k = 0; k < 64; k++) src[k] = 16'($urandom);
    load_range(0, 64);
    run_gen(0, 1'b0, 32'd0);

    repeat (4) @(posedge clk_fast);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_da_lut_loader.md
Name: fir_da_lut_loader

Overview:
- Configuration sequencer for the 64-tap distributed-arithmetic fir_filter.
- Accepts 64 signed 16-bit coefficients over a valid/ready stream and stores them locally.
- On start, generates all 2048 DA LUT entries (8 groups × 256 subset sums) and drives them onto the filter's CIN/CADDR/CLOAD load port.
- Each entry is held for HOLD_CYCLES fast clocks, so a slow-clock-sampling filter captures every entry.

Parameters:
HOLD_CYCLES, 192, fast-clock cycles each LUT entry is held stable on CIN/CADDR; legal range ≥1; default matches the fast/slow clock ratio.

Ports:
clk_fast  in  1  sole clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
coef_in  in  16  signed coefficient; tap index = acceptance order 0..63.
coef_valid  in  1  coefficient offered.
coef_ready  out  1  coefficient accepted when valid&ready.
start  in  1  request LUT generation.
busy  out  1  high while in GEN.
done  out  1  one-cycle pulse when the last entry's hold completes.
CIN  out  19  signed LUT entry value to fir_filter.
CADDR  out  11  LUT address to fir_filter.
CLOAD  out  1  LUT write enable to fir_filter.
filter_en  out  1  high when a complete LUT is loaded; system gates fir_filter valid_in with it.
lut_checksum  out  32  running sum of written entries (see Optional Feature).

Behaviour:
- Reset values: coef_ready=1, busy=0, done=0, CIN=0, CADDR=0, CLOAD=0, filter_en=0, lut_checksum=0; coef_cnt=0; state=IDLE.
- Coefficient storage: 64×16 register file, not cleared by reset (contents don't-care until 64 are written).
- States: IDLE, GEN, DONE.
- IDLE:
  - coef_ready = (coef_cnt<64).
  - Each handshake writes coef[coef_cnt] and increments coef_cnt.
  - The first handshake after a completed load also clears filter_en in the same cycle.
  - Any coefficient offered when coef_cnt==64 is not accepted; ready stays low.
- IDLE→GEN: start sampled high with coef_cnt==64. A start with coef_cnt<64 is ignored (no state change, no error).
- GEN:
  - Cycle after start is sampled: CLOAD=1, busy=1, coef_ready=0, CADDR=0, CIN=entry(0).
  - Each address is held exactly HOLD_CYCLES cycles, then CADDR increments and CIN updates in the same cycle.
  - Both CIN and CADDR are registered outputs and never glitch mid-hold.
  - start is ignored during GEN; coefficients are not accepted.
- Entry arithmetic: for address a, g=a[10:8], m=a[7:0]; entry(a) = Σ coef[8g+b] over bits b where m[b]=1.
  - Signed, sign-extended to 19 bits, exact with no overflow (|sum| ≤ 8·32768).
  - entry(a) = 0 whenever m=0.
- GEN→DONE: after address 2047 completes its hold.
  - Total CLOAD-high time is exactly 2048·HOLD_CYCLES cycles.
- DONE (one cycle): done=1, CLOAD=0, busy=0, filter_en=1, coef_cnt←0; then →IDLE.
  - CADDR/CIN retain their last values (2047, entry(2047)).
  - Stored coefficients are kept.
  - A new load requires 64 fresh coefficients.
- Reset mid-GEN: immediate asynchronous return to the reset values. CLOAD drops at once; the partial LUT is treated as invalid (filter_en=0).
- Simultaneous coef_valid and start in IDLE with coef_cnt==64: start wins; no coefficient accepted.

Optional Feature:
- Macro: FIR_LUT_CHECKSUM_EN.
- Defined:
  - lut_checksum clears when GEN is entered.
  - It adds sign-extended CIN once per address, on that address's first GEN cycle, with modulo-2^32 wrap.
  - Its final value is valid from the DONE cycle and held until the next GEN.
- Undefined: lut_checksum is tied to 0 and the accumulator is not synthesised. The port is always present.

Decomposition:
- Package fir_ctrl_pkg:
  - NUM_TAPS=64, GROUP_SIZE=8, NUM_GROUPS=8, LUT_DEPTH=2048.
  - COEF_W=16, CIN_W=19, CADDR_W=11.
  - State enum {IDLE, GEN, DONE}.
- Sub-module fir_da_subset_sum: purely combinational. Inputs: eight 16-bit coefficients and an 8-bit mask. Output: the 19-bit signed masked sum (adder tree). The loader instantiates it once, fed by the group-g coefficient slice.

Test Plan (HOLD_CYCLES=4 unless stated):
- All 64 coefficients =1, start → CLOAD high exactly 8192 cycles. CADDR 0→CIN 0; CADDR 255→8; CADDR 256+0x0F→4; CADDR 2047→8. done pulses once; filter_en=1 after.
- Coefficient k = k−32, start → CADDR 3 = coef0+coef1 = −32−31 = −63 (19'h7FFC1); CADDR 0x700|0x80 = coef63 = 31.
- All coefficients −32768 → CADDR 255 = −262144 (19'h40000); CADDR 2047 = 19'h40000.
- Start with only 63 coefficients loaded → no CLOAD, busy stays 0. 65th coefficient offered after 64 → coef_ready=0, not stored.
- Assert reset at address 1000 mid-GEN → CLOAD=0, filter_en=0, coef_cnt=0 immediately. Reload 64 coefficients and start → full 2048-entry sequence from address 0.
- FIR_LUT_CHECKSUM_EN defined, coefficients all 1, HOLD_CYCLES=1 → lut_checksum = 8·(8·128) = 8192 at DONE. Macro undefined → lut_checksum = 0 throughout.
